// File: rtl/intlv_pkg.sv
// Shared defaults, scan-mode encodings and FSM state type for the interleaver controller.
package intlv_pkg;

    localparam int ROWS   = 83;
    localparam int COLS   = 148;
    localparam int DEPTH  = ROWS * COLS;
    localparam int ADDR_W = 14;

    localparam logic MODE_ROW = 1'b0;
    localparam logic MODE_COL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/intlv_addr_gen.sv
// Row/column scan address generator; row-major is a linear count, column-major
// strides by COLS and restarts at the next column on row wrap. Wraps to 0 after the last cell.
module intlv_addr_gen #(
    parameter int ROWS   = intlv_pkg::ROWS,
    parameter int COLS   = intlv_pkg::COLS,
    parameter int ADDR_W = intlv_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              step,
    input  logic              clear,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    import intlv_pkg::*;

    localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    assign last = (row == ROW_MAX) && (col == COL_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (clear || (step && last)) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (step) begin
            if (mode == MODE_ROW) begin
                addr <= addr + ONE;
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= row + ONE;
                end else begin
                    col <= col + ONE;
                end
            end else begin
                if (row == ROW_MAX) begin
                    row  <= '0;
                    col  <= col + ONE;
                    addr <= col + ONE;
                end else begin
                    row  <= row + ONE;
                    addr <= addr + COL_STEP;
                end
            end
        end
    end

endmodule

// File: rtl/intlv_ctrl.sv
// Block interleaver controller: writes a frame into the single-port RAM, reads it back
// transposed through a 2-entry skid buffer. INTLV_DEINTERLEAVE_EN swaps the scan orders.
module intlv_ctrl #(
    parameter int ROWS   = intlv_pkg::ROWS,
    parameter int COLS   = intlv_pkg::COLS,
    parameter int ADDR_W = intlv_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_rd,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy,
    output logic              frame_done
);
    import intlv_pkg::*;

`ifdef INTLV_DEINTERLEAVE_EN
    localparam logic WR_MODE = MODE_COL;
    localparam logic RD_MODE = MODE_ROW;
`else
    localparam logic WR_MODE = MODE_ROW;
    localparam logic RD_MODE = MODE_COL;
`endif

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last;
    logic              gen_mode;
    logic              gen_step;
    logic              gen_clear;
    logic              inflight;
    logic [1:0]        count;
    logic [1:0]        occ;
    logic [31:0]       buf0;
    logic [31:0]       buf1;
    logic              wr_fire;
    logic              issue;
    logic              push;
    logic              pop;
    logic              final_pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = buf0;
    assign ram_addr  = gen_addr;
    assign push      = inflight;
    assign pop       = out_valid && out_ready;
    assign occ       = {1'b0, inflight} + count;
    assign wr_fire   = (state == WRITE) && in_valid;
    // A pop in the same cycle frees a slot, which keeps the read path at one word per cycle.
    assign issue     = (state == READ) && ((occ < 2'd2) || (pop && (occ == 2'd2)));
    assign final_pop = (state == DRAIN) && !inflight && (count == 2'd1) && pop;
    assign gen_step  = wr_fire || issue;
    assign gen_clear = (state == IDLE);
    assign gen_mode  = (state == WRITE) ? WR_MODE : RD_MODE;

    intlv_addr_gen #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (gen_mode),
        .step  (gen_step),
        .clear (gen_clear),
        .addr  (gen_addr),
        .last  (gen_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = WRITE;
            WRITE:   if (wr_fire && gen_last) state_next = READ;
            READ:    if (issue && gen_last) state_next = DRAIN;
            DRAIN:   if (final_pop) state_next = WRITE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        ram_cs     = 1'b1;
        ram_rd     = 1'b0;
        ram_wdata  = '0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            WRITE: begin
                in_ready  = 1'b1;
                ram_cs    = ~in_valid;
                ram_wdata = in_data;
                busy      = (gen_addr != '0);
            end
            READ: begin
                ram_cs = 1'b0;
                ram_rd = 1'b1;
                busy   = 1'b1;
            end
            DRAIN: begin
                ram_cs     = ~inflight;
                ram_rd     = inflight;
                busy       = 1'b1;
                frame_done = final_pop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            count    <= '0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            inflight <= issue;
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) buf0 <= ram_rdata;
                    else               buf1 <= ram_rdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf0  <= buf1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf0 <= ram_rdata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_intlv_ctrl.sv
// Scoreboard bench for intlv_ctrl: a 3x4 instance for ordering/stall/reset cases and a
// default-size instance for a full 12284-word frame. Honours INTLV_DEINTERLEAVE_EN.
module tb_intlv_ctrl;
    import intlv_pkg::*;

    localparam int S_ROWS = 3;
    localparam int S_COLS = 4;
    localparam int S_N    = S_ROWS * S_COLS;
    localparam int B_N    = intlv_pkg::DEPTH;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } exp_t;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [31:0] s_in_data, s_out_data, s_ram_wdata, s_ram_rdata;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [13:0] s_ram_addr;
    logic        s_ram_cs, s_ram_rd, s_busy, s_frame_done;

    logic [31:0] b_in_data, b_out_data, b_ram_wdata, b_ram_rdata;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [13:0] b_ram_addr;
    logic        b_ram_cs, b_ram_rd, b_busy, b_frame_done;

    intlv_ctrl #(.ROWS(S_ROWS), .COLS(S_COLS), .ADDR_W(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .ram_addr(s_ram_addr), .ram_cs(s_ram_cs), .ram_rd(s_ram_rd),
        .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata),
        .busy(s_busy), .frame_done(s_frame_done)
    );

    intlv_ctrl #(.ROWS(intlv_pkg::ROWS), .COLS(intlv_pkg::COLS), .ADDR_W(intlv_pkg::ADDR_W)) dut_big (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ram_addr(b_ram_addr), .ram_cs(b_ram_cs), .ram_rd(b_ram_rd),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    // Single-port RAMs with registered read data.
    logic [31:0] s_mem [0:16383];
    logic [31:0] b_mem [0:16383];
    always @(posedge clk) begin
        if (!s_ram_cs) begin
            if (s_ram_rd) s_ram_rdata <= s_mem[s_ram_addr];
            else          s_mem[s_ram_addr] <= s_ram_wdata;
        end
        if (!b_ram_cs) begin
            if (b_ram_rd) b_ram_rdata <= b_mem[b_ram_addr];
            else          b_mem[b_ram_addr] <= b_ram_wdata;
        end
    end

    // Reference mapping: which input word lands at output position k, and where word j is written.
    function automatic int unsigned src_of(input int unsigned k, input int unsigned rows,
                                           input int unsigned cols);
`ifdef INTLV_DEINTERLEAVE_EN
        return (k % cols) * rows + k / cols;
`else
        return (k % rows) * cols + k / rows;
`endif
    endfunction

    function automatic int unsigned wr_addr_of(input int unsigned j, input int unsigned rows,
                                               input int unsigned cols);
`ifdef INTLV_DEINTERLEAVE_EN
        return (j % rows) * cols + j / rows;
`else
        return j + 0 * (rows + cols);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    exp_t        sb[$];
    logic [31:0] bq[$];
    logic [31:0] s_frame [S_N];
    logic [31:0] b_frame [B_N];
    bit          rdy_rand = 1'b0;

    task automatic push_expected();
        for (int k = 0; k < S_N; k++) begin
            exp_t e;
            e.data = s_frame[src_of(k, S_ROWS, S_COLS)];
            e.last = (k == S_N - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_small(input bit gaps);
        int unsigned i = 0;
        int unsigned guard = 0;
        bit acc;
        while (i < S_N && guard < 1000) begin
            s_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_in_data  = s_frame[i];
            @(negedge clk);
            acc = s_in_valid && s_in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        s_in_valid = 1'b0;
        check("send_small_timeout", i, S_N);
    endtask

    task automatic wait_drain(input string name);
        int unsigned c = 0;
        while (sb.size() != 0 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d words still pending after timeout", name, sb.size());
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_busy_after"}, s_busy, 1'b0);
        check({name, "_ready_after"}, s_in_ready, 1'b1);
    endtask

    task automatic reset_checks(input string name);
        check({name, "_in_ready"}, s_in_ready, 1'b0);
        check({name, "_out_valid"}, s_out_valid, 1'b0);
        check({name, "_out_data"}, s_out_data, 32'h0);
        check({name, "_ram_ctl"}, {s_ram_cs, s_ram_rd}, 2'b10);
        check({name, "_ram_addr"}, s_ram_addr, 14'h0);
        check({name, "_busy_done"}, {s_busy, s_frame_done}, 2'b00);
    endtask

    // Output ready pattern for the small instance.
    initial begin
        s_out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            s_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Small-instance monitor: write addressing, stall stability and scoreboard ordering.
    int unsigned wr_idx = 0;
    int unsigned out_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_idx     = 0;
            prev_stall = 1'b0;
        end else begin
            if (s_in_valid && s_in_ready) begin
                check("wr_addr", s_ram_addr, wr_addr_of(wr_idx, S_ROWS, S_COLS));
                check("wr_ctl", {s_ram_cs, s_ram_rd}, 2'b00);
                check("wr_data", s_ram_wdata, s_in_data);
                wr_idx = (wr_idx + 1) % S_N;
            end else if (s_in_ready) begin
                check("gap_cs", s_ram_cs, 1'b1);
            end
            if (prev_stall) begin
                check("stall_valid", s_out_valid, 1'b1);
                check("stall_data", s_out_data, prev_data);
            end
            if (s_out_valid && s_out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h, expected no output", s_out_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", s_out_data, mon_e.data);
                    check("frame_done", s_frame_done, mon_e.last);
                end
                out_cnt++;
            end else begin
                check("frame_done_idle", s_frame_done, 1'b0);
            end
            prev_stall = s_out_valid && !s_out_ready;
            prev_data  = s_out_data;
        end
    end

    // Default-size monitor.
    int unsigned b_max_addr = 0;
    int unsigned b_done_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!b_ram_cs && b_ram_rd && 32'(b_ram_addr) > b_max_addr) b_max_addr = 32'(b_ram_addr);
            if (b_frame_done) b_done_cnt++;
            if (b_out_valid && b_out_ready) begin
                if (bq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL big_unexpected_out: got %0h, expected no output", b_out_data);
                end else begin
                    check("big_out", b_out_data, bq.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        int unsigned i;
        int unsigned guard;
        bit acc;
        rst_n = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        #12;
        reset_checks("rst");
        @(negedge clk); rst_n = 1'b1; #1;
        check("idle_in_ready", s_in_ready, 1'b0);
        @(posedge clk); #1;
        check("first_in_ready", s_in_ready, 1'b1);

        // Frame A: ordered data, back-to-back, out_ready high.
        for (int k = 0; k < S_N; k++) begin
`ifdef INTLV_DEINTERLEAVE_EN
            s_frame[src_of(k, S_ROWS, S_COLS)] = k;
`else
            s_frame[k] = k;
`endif
        end
        push_expected();
        send_small(1'b0);
        wait_drain("frame_a");

        // Frame B: random data, input gaps, random output stalls.
        for (int k = 0; k < S_N; k++) s_frame[k] = $urandom;
        rdy_rand = 1'b1;
        push_expected();
        send_small(1'b1);
        wait_drain("frame_b");

        // Frame C: reset asserted after seven outputs.
        for (int k = 0; k < S_N; k++) s_frame[k] = $urandom;
        base = out_cnt;
        push_expected();
        send_small(1'b0);
        for (int c = 0; c < 500 && out_cnt < base + 7; c++) @(posedge clk);
        check("reset_point_reached", out_cnt >= base + 7, 1'b1);
        #2 rst_n = 1'b0;
        #1 reset_checks("mid_rst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame D: normal frame after the mid-frame reset.
        for (int k = 0; k < S_N; k++) s_frame[k] = $urandom;
        push_expected();
        send_small(1'b1);
        wait_drain("frame_d");
        rdy_rand = 1'b0;

        // Default-size frame.
        for (int k = 0; k < B_N; k++) b_frame[k] = $urandom;
        for (int k = 0; k < B_N; k++) bq.push_back(b_frame[src_of(k, intlv_pkg::ROWS, intlv_pkg::COLS)]);
        i = 0;
        guard = 0;
        while (i < B_N && guard < 20000) begin
            b_in_valid = 1'b1;
            b_in_data  = b_frame[i];
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        b_in_valid = 1'b0;
        check("big_send_timeout", i, B_N);
        guard = 0;
        while (bq.size() != 0 && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        check("big_pending", bq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("big_max_rd_addr", b_max_addr, B_N - 1);
        check("big_frame_done_cnt", b_done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/intlv_ctrl.md
# intlv_ctrl

Block-interleaver controller that owns the single-port 32-bit interleaver RAM (14-bit address, active-low chip select, `rd` high = read / low = write, registered read data). It accepts a frame of `ROWS*COLS` words on a valid/ready stream, writes them row-major into the RAM, then reads them back column-major and presents them on an output valid/ready stream. It sits between the LFSR scrambler output and the downstream modulator/serializer, and is the only master of the RAM.

## Interface
- `ROWS`, 83, interleaver rows
- `COLS`, 148, interleaver columns; `ROWS*COLS` ≤ 12284 (default exactly 12284)
- `ADDR_W`, 14, RAM address width
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_data` in 32: frame word; `in_valid` in 1; `in_ready` out 1
- `out_data` out 32: interleaved word; `out_valid` out 1; `out_ready` in 1
- `ram_addr` out 14; `ram_cs` out 1, active low; `ram_rd` out 1; `ram_wdata` out 32; `ram_rdata` in 32
- `busy` out 1: high outside IDLE/WRITE-with-zero-words
- `frame_done` out 1: one-cycle pulse on last output handshake

## Operation
- States: IDLE → WRITE → READ → DRAIN → WRITE. IDLE lasts exactly one cycle after reset release.
- WRITE: `in_ready`=1; `ram_rd`=0; `ram_cs`=~`in_valid`; `ram_wdata`=`in_data`; `ram_addr`=write address. Each handshake advances the write counter. Handshake on word `ROWS*COLS-1` → READ.
- READ: `ram_cs`=0, `ram_rd`=1 held continuously. A read is issued (address advances) only when in-flight reads + buffered words < 2. Data appears on `ram_rdata` the cycle after issue and is pushed into a 2-entry output skid buffer that cycle. After the last issue → DRAIN.
- DRAIN: `ram_cs`=0, `ram_rd`=1 for the one cycle that captures the last word, then `ram_cs`=1; wait until buffer empty; `frame_done` pulses with the final `out_valid && out_ready`; next state WRITE.
- Address generation, no multipliers: row-major = linear counter 0…N-1. Column-major = `addr += COLS`; on row wrap `addr = col+1`. All arithmetic on `ADDR_W` bits; N-1 never exceeds 12283.
- `out_valid` = buffer non-empty; `out_data` = buffer head; buffer must accept a push and a pop in the same cycle.
- `in_valid` during READ/DRAIN: ignored (`in_ready`=0, no data loss obligation).
- `out_valid` never drops without a handshake; `out_data` stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `in_ready`=0, `out_valid`=0, `out_data`=0, `ram_cs`=1, `ram_rd`=0, `ram_addr`=0, `busy`=0, `frame_done`=0, counters 0.
- Read latency: issue cycle N → `out_valid` at N+2 with `out_ready` held high; sustained throughput 1 word/cycle.
- Write throughput 1 word/cycle; first `in_ready` high in cycle 2 after reset release.
- Reset mid-frame: all state discarded immediately; RAM contents not cleared; next frame starts at address 0.
- WRITE→READ turnaround: first read issued the cycle after the last write.

## Configuration
- `INTLV_DEINTERLEAVE_EN`: defined → write address column-major, read address row-major (deinterleaver, inverts the default mapping). Undefined → write row-major, read column-major (interleaver). Handshakes and timing identical.

## Structure
- Package `intlv_pkg`: default `ROWS`, `COLS`, `DEPTH`=`ROWS*COLS`, `ADDR_W`, state enum `{IDLE, WRITE, READ, DRAIN}`.
- Sub-module `intlv_addr_gen`: row/column counters with `mode` (row-major/column-major), `step`, `clear`, outputs `addr`, `last`; instantiated once, reused for both phases.

## Test plan
- ROWS=3, COLS=4, input 0…11 back-to-back, `out_ready`=1 → output 0,4,8,1,5,9,2,6,10,3,7,11; `frame_done` with 11.
- Same, `INTLV_DEINTERLEAVE_EN` defined, input 0,4,8,1,5,9,2,6,10,3,7,11 → output 0…11.
- `out_ready` toggling 1-0-0-1 random → no loss/duplication, `out_data` stable while stalled, ≤2 reads outstanding.
- `in_valid` gaps in WRITE → `ram_cs`=1 on gap cycles, addresses contiguous 0…11.
- `rst_n` low at word 7 of READ → all outputs at reset values asynchronously; next frame output order correct.
- Default parameters, 12284 words → final read address 12283, no wrap past 12283, `frame_done` once.
